// File: rtl/retro_cache_pkg.sv
// Shared definitions for the cartridge-cache line filler.
//   fill_state_t : filler FSM states
//   CACHE_LINE_BITS / LINE_BYTES / COUNT_W : default line geometry
//   align_line() : clears the in-line offset bits of a byte address
package retro_cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    SETTLE = 2'd2
  } fill_state_t;

  localparam int CACHE_LINE_BITS = 7;
  localparam int LINE_BYTES      = 1 << CACHE_LINE_BITS;
  // One extra bit so a counter can reach LINE_BYTES and mean "done".
  localparam int COUNT_W         = CACHE_LINE_BITS + 1;

  // Wide enough for any realistic bank+address concatenation; callers
  // size-cast the result back to their own address width.
  localparam int ALIGN_W = 64;

  function automatic logic [ALIGN_W-1:0] align_line(input logic [ALIGN_W-1:0] addr,
                                                    input int line_bits);
    logic [ALIGN_W-1:0] mask;
    mask = '1;
    mask = mask << line_bits;
    return addr & mask;
  endfunction

endpackage

// File: rtl/cache_fill_counter.sv
// Issue/receive byte counters for one line fill.
//   clk, reset_n   : clock, synchronous active-low reset
//   clear          : hold both counters at zero (filler idle)
//   issue_inc      : a backing-store request was accepted
//   recv_inc       : a response byte was written into the cache
//   issue_count    : requests accepted so far in this line
//   recv_count     : bytes received so far in this line
//   issue_done     : every byte of the line has been requested
//   recv_last      : the next received byte is the final one of the line
module cache_fill_counter #(
  parameter int LineBits = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              issue_inc,
  input  logic              recv_inc,
  output logic [LineBits:0] issue_count,
  output logic [LineBits:0] recv_count,
  output logic              issue_done,
  output logic              recv_last
);

  localparam logic [LineBits:0] ONE      = 1;
  localparam logic [LineBits:0] LAST_OFF = (1 << LineBits) - 1;

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      issue_count <= '0;
      recv_count  <= '0;
    end else begin
      if (issue_inc) issue_count <= issue_count + ONE;
      if (recv_inc)  recv_count  <= recv_count + ONE;
    end
  end

  // The top bit only sets once the count reaches the line size.
  assign issue_done = issue_count[LineBits];
  assign recv_last  = (recv_count == LAST_OFF);

endmodule

// File: rtl/cache_line_filler.sv
// Miss-service controller in front of the one-cycle cartridge cache.
// On a core read miss it stalls the core (Delay), takes the cache port,
// streams one aligned line from the backing store into the cache, then
// spends one SETTLE cycle handing the port back so the replayed access hits.
//
// Ports
//   Clk, ResetN        : single clock, synchronous active-low reset
//   CoreAccess/Write   : core access strobe / write qualifier
//   CoreAddress/Bank   : core address within bank, current bank number
//   CacheDataReady     : cache hit for the current core read
//   Delay              : stall request to the CCCU
//   FillOwnsCache      : cache-port mux select (1 = filler)
//   FillAccess/Address/Data : cache write port driven during a fill
//   MemRead/MemAddress : backing-store request, held until MemReady
//   MemReady           : request accepted this cycle
//   MemValid/MemData   : in-order read response
//
// Handshake: a request transfers on a cycle where MemRead && MemReady;
// MemRead and MemAddress do not change until that cycle. Responses need
// no back-pressure: every MemValid cycle carries exactly one byte for the
// oldest outstanding request.
module cache_line_filler
  import retro_cache_pkg::*;
#(
  parameter int AddressBusWidth = 16,
  parameter int BankBits        = 8,
  parameter int DataBusWidth    = 8,
  parameter int CacheLineBits   = CACHE_LINE_BITS
) (
  input  logic                                Clk,
  input  logic                                ResetN,
  input  logic                                CoreAccess,
  input  logic                                CoreWrite,
  input  logic [AddressBusWidth-1:0]          CoreAddress,
  input  logic [BankBits-1:0]                 CoreBank,
  input  logic                                CacheDataReady,
  output logic                                Delay,
  output logic                                FillOwnsCache,
  output logic                                FillAccess,
  output logic [AddressBusWidth+BankBits-1:0] FillAddress,
  output logic [DataBusWidth-1:0]             FillData,
  output logic                                MemRead,
  output logic [AddressBusWidth+BankBits-1:0] MemAddress,
  input  logic                                MemReady,
  input  logic                                MemValid,
  input  logic [DataBusWidth-1:0]             MemData
);

  localparam int FullW = AddressBusWidth + BankBits;
  localparam int CntW  = CacheLineBits + 1;

  fill_state_t      state;
  logic [FullW-1:0] line_base;
  logic             delay_q;
  logic             owns_q;

  logic [CntW-1:0]  issue_count;
  logic [CntW-1:0]  recv_count;
  logic             issue_done;
  logic             recv_last;

  logic             miss;
  logic             start;
  logic             mem_read;
  logic             fill_access;
  logic [FullW-1:0] issue_addr;
  logic [FullW-1:0] recv_addr;

  assign miss  = CoreAccess & ~CoreWrite & ~CacheDataReady;
  // Only an idle filler reacts to the core; while filling, Delay has the
  // core frozen and whatever it presents is stale.
  assign start = ResetN & (state == IDLE) & miss;

  assign mem_read = (state == FILL) & ~issue_done;
  // A response with nothing outstanding (or outside FILL) is dropped.
  assign fill_access = (state == FILL) & MemValid & (recv_count != issue_count);

  // The line is aligned, so OR-ing the offset in never carries.
  assign issue_addr = line_base | {{(FullW-CntW){1'b0}}, issue_count};
  assign recv_addr  = line_base | {{(FullW-CntW){1'b0}}, recv_count};

  cache_fill_counter #(
    .LineBits (CacheLineBits)
  ) u_counter (
    .clk         (Clk),
    .reset_n     (ResetN),
    .clear       (state == IDLE),
    .issue_inc   (mem_read & MemReady),
    .recv_inc    (fill_access),
    .issue_count (issue_count),
    .recv_count  (recv_count),
    .issue_done  (issue_done),
    .recv_last   (recv_last)
  );

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state     <= IDLE;
      line_base <= '0;
      delay_q   <= 1'b0;
      owns_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            line_base <= FullW'(align_line(ALIGN_W'({CoreBank, CoreAddress}), CacheLineBits));
            state     <= FILL;
            delay_q   <= 1'b1;
            owns_q    <= 1'b1;
          end
        end
        FILL: begin
          if (fill_access && recv_last) begin
            state  <= SETTLE;
            owns_q <= 1'b0;
          end
        end
        SETTLE: begin
          // Port is back with the core; Delay drops next cycle for the replay.
          state   <= IDLE;
          delay_q <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          delay_q <= 1'b0;
          owns_q  <= 1'b0;
        end
      endcase
    end
  end

  // Delay rises combinationally in the miss cycle, then stays registered.
  assign Delay         = start | delay_q;
  assign FillOwnsCache = owns_q;
  assign MemRead       = mem_read;
  assign MemAddress    = mem_read ? issue_addr : '0;
  assign FillAccess    = fill_access;
  assign FillAddress   = fill_access ? recv_addr : '0;
  assign FillData      = fill_access ? MemData : '0;

  a_mem_valid_expected : assert property (@(posedge Clk) disable iff (!ResetN)
    MemValid |-> fill_access)
    else $warning("cache_line_filler: MemValid with no outstanding request, byte dropped");

endmodule
